lbus_responder: RTL and testbench
=================================

LBUS_RESPONDER -- requirements
Module: lbus_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset, with ports: clk  input  1  system clock, all logic on rising edge; rst  input  1  synchronous reset, active-low (0 = reset).
REQ-002 lbus_a  input  16  word address from the bus controller.
REQ-003 lbus_di  input  16  write data from the controller.
REQ-004 lbus_wrn  input  1  write strobe, active-low, held low at least 4 clk cycles.
REQ-005 lbus_rdn  input  1  read strobe, active-low, held low at least 4 clk cycles.
REQ-006 lbus_do  output  16  read data to the controller.
REQ-007 core_key  output  128  key register, word 0x0100 holds bits [127:112].
REQ-008 core_din  output  128  text-in register, word 0x0140 holds bits [127:112].
REQ-009 core_start  output  1  one-cycle start pulse to the crypto core.
REQ-010 core_dout  input  128  core result.
REQ-011 core_done  input  1  one-cycle result-valid pulse.

Function
REQ-012 lbus_wrn and lbus_rdn SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized copy (previous 1, current 0).
REQ-013 On a detected wrn fall, the block SHALL capture lbus_a and lbus_di in the same cycle and commit the write on the next cycle.
REQ-014 On a detected rdn fall, the block SHALL register the addressed word onto lbus_do one cycle later (≤4 clk after the raw rdn fall), and lbus_do SHALL hold until the next read.
REQ-015 Register map:
  0x0000 CONT: W bit0 = start (self-clearing); R bit2 = busy.
  0x0100-0x010E KEY: R/W, 8 words, even addresses only.
  0x0140-0x014E TEXT_IN: R/W.
  0x0180-0x018E TEXT_OUT: read-only.
  0xFFFC VERSION: R 0x0001.
REQ-016 Odd or unmapped addresses SHALL read 0x0000; writes to them SHALL be ignored.
REQ-017 Control FSM states: IDLE, START, BUSY.
  IDLE→START on a CONT write with bit0=1.
  START asserts core_start for exactly 1 cycle, then goes to BUSY.
  BUSY→IDLE on core_done; TEXT_OUT captures core_dout in that cycle.
REQ-018 busy SHALL read 1 in START and BUSY.
REQ-019 While busy: writes to KEY, TEXT_IN and CONT SHALL be ignored.
REQ-020 core_done in IDLE or START SHALL be ignored; TEXT_OUT is unchanged.
REQ-021 A write and a read detected in the same cycle: the write SHALL be performed, the read dropped, and lbus_do unchanged.
REQ-022 A strobe held low beyond 4 cycles SHALL produce exactly one access; the next access requires the strobe to return high first.

Reset
REQ-023 With rst=0 at a clk edge, the following SHALL clear to 0: lbus_do, KEY, TEXT_IN, TEXT_OUT, core_start. The FSM SHALL go to IDLE, and synchronizers and edge detectors SHALL be preset to 1 (idle-high).
REQ-024 Reset mid-operation SHALL abandon any pending access or core run; a core_done after reset is ignored.
REQ-025 A strobe already low when reset releases SHALL NOT be treated as an edge.

Configuration
REQ-026 The macro LBUS_KEY_READBACK_EN SHALL control KEY readback:
  Defined: KEY words read back their stored value.
  Undefined: KEY reads return 0x0000, and KEY remains writable and drives core_key.

Verification
REQ-027 Write 0x2B7E to 0x0100, then read 0x0100 → lbus_do=0x2B7E with the macro defined; 0x0000 with it undefined; core_key[127:112]=0x2B7E in both cases.
REQ-028 Write 0x0001 to 0x0000 → core_start high for exactly 1 cycle; a CONT read returns 0x0004. Pulse core_done with core_dout=128'h3925...0B32 → a CONT read returns 0x0000 and a read of 0x0180 returns 0x3925.
REQ-029 While busy, write 0xFFFF to 0x0140, then issue a second start → TEXT_IN is unchanged and no additional core_start occurs.
REQ-030 Reads of 0x0003, 0x0200 and 0xFFFC → 0x0000, 0x0000 and 0x0001.
REQ-031 Hold wrn low for 20 cycles, writing 0x0001 to CONT → exactly one core_start. Drop wrn and rdn in the same cycle → the write occurs and lbus_do is unchanged.
REQ-032 Assert rst=0 during BUSY → IDLE, TEXT_OUT=0, and a later core_done leaves TEXT_OUT=0.

Source files
------------

// File: rtl/lbus_if.sv
// Local-bus signal bundle between the bus controller (master) and a responder (slave).
interface lbus_if;
    logic [15:0] lbus_a;
    logic [15:0] lbus_di;
    logic [15:0] lbus_do;
    logic        lbus_wrn;
    logic        lbus_rdn;

    modport master (
        output lbus_a,
        output lbus_di,
        output lbus_wrn,
        output lbus_rdn,
        input  lbus_do
    );

    modport slave (
        input  lbus_a,
        input  lbus_di,
        input  lbus_wrn,
        input  lbus_rdn,
        output lbus_do
    );
endinterface

// File: rtl/lbus_responder.sv
// Local-bus register responder for a 128-bit crypto core (key, text in/out, start/busy).
// Macro LBUS_KEY_READBACK_EN enables readback of the KEY words; otherwise they read 0x0000.
module lbus_responder (
    input  logic         clk,
    input  logic         rst,
    lbus_if.slave        bus,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    output logic         core_start,
    input  logic [127:0] core_dout,
    input  logic         core_done
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

    state_e       state_q, state_d;
    logic [1:0]   wr_sync_q, rd_sync_q;
    logic         wr_prev_q, rd_prev_q;
    logic [2:0]   settle_q;
    logic         wr_fall, rd_fall;
    logic         wr_pend_q, rd_pend_q;
    logic [15:0]  addr_q, wdata_q;
    logic [127:0] key_q, din_q, tout_q;
    logic [15:0]  do_q, rdata;
    logic         busy, wr_commit, key_we, din_we, start_req;
    logic         is_cont, is_key, is_din, is_tout, is_ver;
    logic [6:0]   word_base;

    // Edges are only trusted once the synchronizers and prev flops hold post-reset samples,
    // so a strobe already low at reset release is not mistaken for a fall.
    assign wr_fall = settle_q[2] & wr_prev_q & ~wr_sync_q[1];
    assign rd_fall = settle_q[2] & rd_prev_q & ~rd_sync_q[1];

    assign busy      = (state_q != StIdle);
    assign wr_commit = wr_pend_q & ~busy;
    assign word_base = {~addr_q[3:1], 4'b0000};

    assign is_cont = (addr_q == 16'h0000);
    assign is_key  = (addr_q[15:4] == 12'h010) & ~addr_q[0];
    assign is_din  = (addr_q[15:4] == 12'h014) & ~addr_q[0];
    assign is_tout = (addr_q[15:4] == 12'h018) & ~addr_q[0];
    assign is_ver  = (addr_q == 16'hFFFC);

    assign key_we    = wr_commit & is_key;
    assign din_we    = wr_commit & is_din;
    assign start_req = wr_commit & is_cont & wdata_q[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_sync_q <= 2'b11;
            rd_sync_q <= 2'b11;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
            settle_q  <= 3'b000;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            key_q     <= '0;
            din_q     <= '0;
            tout_q    <= '0;
            do_q      <= 16'h0000;
        end else begin
            wr_sync_q <= {wr_sync_q[0], bus.lbus_wrn};
            rd_sync_q <= {rd_sync_q[0], bus.lbus_rdn};
            wr_prev_q <= wr_sync_q[1];
            rd_prev_q <= rd_sync_q[1];
            settle_q  <= {settle_q[1:0], 1'b1};
            wr_pend_q <= wr_fall;
            // A simultaneous write wins; the read is dropped.
            rd_pend_q <= rd_fall & ~wr_fall;
            if (wr_fall || rd_fall) addr_q <= bus.lbus_a;
            if (wr_fall) wdata_q <= bus.lbus_di;
            if (key_we) key_q[word_base +: 16] <= wdata_q;
            if (din_we) din_q[word_base +: 16] <= wdata_q;
            if (state_q == StBusy && core_done) tout_q <= core_dout;
            if (rd_pend_q) do_q <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        unique case (state_q)
            StIdle:  if (start_req) state_d = StStart;
            StStart: begin
                core_start = 1'b1;
                state_d    = StBusy;
            end
            StBusy:  if (core_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata = 16'h0000;
        if (is_cont) begin
            rdata = {13'h0000, busy, 2'b00};
        end else if (is_key) begin
`ifdef LBUS_KEY_READBACK_EN
            rdata = key_q[word_base +: 16];
`else
            rdata = 16'h0000;
`endif
        end else if (is_din) begin
            rdata = din_q[word_base +: 16];
        end else if (is_tout) begin
            rdata = tout_q[word_base +: 16];
        end else if (is_ver) begin
            rdata = 16'h0001;
        end
    end

    assign bus.lbus_do = do_q;
    assign core_key    = key_q;
    assign core_din    = din_q;

endmodule

// File: tb/tb_lbus_responder.sv
// Directed self-checking bench for lbus_responder: register map, start/busy FSM,
// strobe edge handling, reset behaviour and the optional KEY readback.
module tb_lbus_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] core_key, core_din, core_dout;
    logic         core_start, core_done;
    logic [15:0]  rd;
    int           pass_cnt  = 0;
    int           fail_cnt  = 0;
    int           check_cnt = 0;
    int           start_cnt = 0;
    int           s0;
    logic [15:0]  exp_key;

    localparam logic [127:0] AesOut = 128'h3925841D02DC09FBDC118597196A0B32;

    always #5 clk = ~clk;

    lbus_if bus ();

    lbus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .core_key   (core_key),
        .core_din   (core_din),
        .core_start (core_start),
        .core_dout  (core_dout),
        .core_done  (core_done)
    );

    always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        bus.lbus_a   = a;
        bus.lbus_di  = d;
        bus.lbus_wrn = 1'b0;
        idle(hold);
        bus.lbus_wrn = 1'b1;
        idle(4);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.lbus_a   = a;
        bus.lbus_rdn = 1'b0;
        idle(6);
        d = bus.lbus_do;
        bus.lbus_rdn = 1'b1;
        idle(4);
    endtask

    task automatic done_pulse(input logic [127:0] v);
        @(negedge clk);
        core_dout = v;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    initial begin
`ifdef LBUS_KEY_READBACK_EN
        exp_key = 16'h2B7E;
`else
        exp_key = 16'h0000;
`endif
        bus.lbus_a   = 16'h0000;
        bus.lbus_di  = 16'h0000;
        bus.lbus_wrn = 1'b1;
        bus.lbus_rdn = 1'b1;
        core_done    = 1'b0;
        core_dout    = '0;
        rst          = 1'b0;
        idle(3);
        check("rst_do", {112'h0, bus.lbus_do}, 128'h0);
        check("rst_key", core_key, 128'h0);
        check("rst_din", core_din, 128'h0);
        check("rst_start", {127'h0, core_start}, 128'h0);
        rst = 1'b1;
        idle(4);

        bus_write(16'h0100, 16'h2B7E, 6);
        bus_read(16'h0100, rd);
        check("key0_read", {112'h0, rd}, {112'h0, exp_key});
        check("key0_core", {112'h0, core_key[127:112]}, 128'h2B7E);
        bus_write(16'h010E, 16'h1234, 6);
        check("key7_core", {112'h0, core_key[15:0]}, 128'h1234);
        bus_write(16'h0140, 16'hA5A5, 6);
        bus_read(16'h0140, rd);
        check("din0_read", {112'h0, rd}, 128'hA5A5);
        check("din0_core", {112'h0, core_din[127:112]}, 128'hA5A5);

        bus_read(16'hFFFC, rd);
        check("version", {112'h0, rd}, 128'h0001);
        bus_read(16'h0003, rd);
        check("odd_addr", {112'h0, rd}, 128'h0);
        bus_read(16'h0200, rd);
        check("unmapped", {112'h0, rd}, 128'h0);
        bus_read(16'h0101, rd);
        check("odd_key", {112'h0, rd}, 128'h0);

        s0 = start_cnt;
        bus_write(16'h0000, 16'h0001, 6);
        check("one_start", 128'(start_cnt - s0), 128'd1);
        bus_read(16'h0000, rd);
        check("cont_busy", {112'h0, rd}, 128'h0004);

        bus_write(16'h0140, 16'hFFFF, 6);
        bus_write(16'h0100, 16'hFFFF, 6);
        bus_write(16'h0000, 16'h0001, 6);
        check("busy_din_kept", {112'h0, core_din[127:112]}, 128'hA5A5);
        check("busy_key_kept", {112'h0, core_key[127:112]}, 128'h2B7E);
        check("busy_no_restart", 128'(start_cnt - s0), 128'd1);
        bus_read(16'h0000, rd);
        check("still_busy", {112'h0, rd}, 128'h0004);

        done_pulse(AesOut);
        bus_read(16'h0000, rd);
        check("cont_idle", {112'h0, rd}, 128'h0);
        bus_read(16'h0180, rd);
        check("tout0", {112'h0, rd}, 128'h3925);
        bus_read(16'h018E, rd);
        check("tout7", {112'h0, rd}, 128'h0B32);
        done_pulse({128{1'b1}});
        bus_read(16'h0180, rd);
        check("idle_done_ignored", {112'h0, rd}, 128'h3925);

        s0 = start_cnt;
        bus_write(16'h0000, 16'h0001, 20);
        check("held_wrn_one_start", 128'(start_cnt - s0), 128'd1);
        done_pulse(AesOut);
        idle(2);

        bus_read(16'hFFFC, rd);
        @(negedge clk);
        bus.lbus_a   = 16'h0140;
        bus.lbus_di  = 16'h5A5A;
        bus.lbus_wrn = 1'b0;
        bus.lbus_rdn = 1'b0;
        idle(6);
        check("wr_rd_do_kept", {112'h0, bus.lbus_do}, 128'h0001);
        bus.lbus_wrn = 1'b1;
        bus.lbus_rdn = 1'b1;
        idle(4);
        check("wr_rd_write_done", {112'h0, core_din[127:112]}, 128'h5A5A);

        bus_write(16'h0000, 16'h0001, 6);
        bus_read(16'h0000, rd);
        check("busy_before_rst", {112'h0, rd}, 128'h0004);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("rst_busy_start", {127'h0, core_start}, 128'h0);
        rst = 1'b1;
        idle(4);
        check("rst_busy_key", core_key, 128'h0);
        bus_read(16'h0000, rd);
        check("rst_busy_idle", {112'h0, rd}, 128'h0);
        bus_read(16'h0180, rd);
        check("rst_busy_tout", {112'h0, rd}, 128'h0);
        done_pulse(AesOut);
        bus_read(16'h0180, rd);
        check("rst_late_done", {112'h0, rd}, 128'h0);

        @(negedge clk);
        bus.lbus_a   = 16'hFFFC;
        bus.lbus_rdn = 1'b0;
        rst          = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(10);
        check("low_at_release", {112'h0, bus.lbus_do}, 128'h0);
        bus.lbus_rdn = 1'b1;
        idle(4);
        bus_read(16'hFFFC, rd);
        check("read_after_release", {112'h0, rd}, 128'h0001);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
